// File: rtl/pool_pkg.sv
// Shared pooling types and defaults: tree fan-in, controller state encoding, default widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pool_pkg;

   localparam int TREE_N  = 10;
   localparam int BW_DEF  = 8;
   localparam int LAT_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      ISSUE = 3'd2,
      DRAIN = 3'd3,
      OUT   = 3'd4
   } pool_state_t;

endpackage

// File: rtl/max_n10.sv
// 10-input unsigned max tree, fully pipelined, no reset on the datapath or valid chain.
// Latency: 4 cycles from den_in to den_out/data_max.
// Backpressure: none; accepts a new group every cycle.
module max_n10 #(
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          den_in,
   input  logic [BW-1:0] data_in0,
   input  logic [BW-1:0] data_in1,
   input  logic [BW-1:0] data_in2,
   input  logic [BW-1:0] data_in3,
   input  logic [BW-1:0] data_in4,
   input  logic [BW-1:0] data_in5,
   input  logic [BW-1:0] data_in6,
   input  logic [BW-1:0] data_in7,
   input  logic [BW-1:0] data_in8,
   input  logic [BW-1:0] data_in9,
   output logic          den_out,
   output logic [BW-1:0] data_max
);

   function automatic logic [BW-1:0] mx(input logic [BW-1:0] a, input logic [BW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   logic [3:0]    den_q;
   logic [BW-1:0] s1_q [5];
   logic [BW-1:0] s2_q [3];
   logic [BW-1:0] s3_q [2];
   logic [BW-1:0] s4_q;

   // Four compare stages; odd leftovers pass straight through to the next stage
   always_ff @(posedge clk) begin
      den_q   <= {den_q[2:0], den_in};
      s1_q[0] <= mx(data_in0, data_in1);
      s1_q[1] <= mx(data_in2, data_in3);
      s1_q[2] <= mx(data_in4, data_in5);
      s1_q[3] <= mx(data_in6, data_in7);
      s1_q[4] <= mx(data_in8, data_in9);
      s2_q[0] <= mx(s1_q[0], s1_q[1]);
      s2_q[1] <= mx(s1_q[2], s1_q[3]);
      s2_q[2] <= s1_q[4];
      s3_q[0] <= mx(s2_q[0], s2_q[1]);
      s3_q[1] <= s2_q[2];
      s4_q    <= mx(s3_q[0], s3_q[1]);
   end

   assign den_out  = den_q[3];
   assign data_max = s4_q;

endmodule

// File: rtl/max_pool_ctrl.sv
// Frame max-pool controller: packs samples into 10-wide groups for max_n10 and folds the results.
// Latency: frame result valid LAT+2 cycles after the last group issue.
// Backpressure: s_ready only in FILL (one bubble per group); m_data held while m_valid && !m_ready.
module max_pool_ctrl
   import pool_pkg::*;
#(
   parameter int BW  = BW_DEF,
   parameter int LW  = 16,
   parameter int LAT = LAT_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [LW-1:0] cfg_len,
   output logic          err_len,
   output logic          busy,
   input  logic          s_valid,
   input  logic [BW-1:0] s_data,
   output logic          s_ready,
   output logic          m_valid,
   output logic [BW-1:0] m_data,
   input  logic          m_ready
);

   localparam int IW = $clog2(TREE_N);
   localparam int CW = $clog2(LAT + 2);

   pool_state_t   state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [BW-1:0] run_max_q, run_max_d;
   logic [BW-1:0] slot_q [TREE_N];
   logic [BW-1:0] slot_d [TREE_N];
   logic          err_q, err_d;
   logic          den_in, den_out;
   logic [BW-1:0] data_max;
   logic          s_fire, ret_ok;

   // Next-state, slot packing, running-max fold and in-flight accounting
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      run_max_d  = run_max_q;
      slot_d     = slot_q;
      inflight_d = inflight_q;
      err_d      = 1'b0;
      busy       = (state_q != IDLE);
      s_ready    = (state_q == FILL);
      m_valid    = (state_q == OUT);
      den_in     = (state_q == ISSUE);
      s_fire     = s_ready && s_valid;
      // Tree output with nothing in flight is stale (max_n10 is not reset) and is dropped
      ret_ok     = den_out && (inflight_q != '0);

      if (ret_ok && (data_max > run_max_q)) begin
         run_max_d = data_max;
      end

      unique case ({den_in, ret_ok})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_len != '0) begin
                  state_d   = FILL;
                  rem_d     = cfg_len;
                  idx_d     = '0;
                  run_max_d = '0;
                  for (int k = 0; k < TREE_N; k++) slot_d[k] = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FILL: begin
            if (s_fire) begin
               slot_d[idx_q] = s_data;
               idx_d         = idx_q + 1'b1;
               rem_d         = rem_q - 1'b1;
               if ((idx_q == IW'(TREE_N - 1)) || (rem_q == LW'(1))) begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            // Cleared slots are zero, so a short final group is padded with the max identity
            for (int k = 0; k < TREE_N; k++) slot_d[k] = '0;
            idx_d   = '0;
            state_d = (rem_q != '0) ? FILL : DRAIN;
         end
         DRAIN: begin
            if (inflight_q == '0) state_d = OUT;
         end
         OUT: begin
            if (m_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Register update; synchronous reset aborts any frame in progress
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rem_q      <= '0;
         inflight_q <= '0;
         run_max_q  <= '0;
         err_q      <= 1'b0;
         for (int k = 0; k < TREE_N; k++) slot_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         run_max_q  <= run_max_d;
         err_q      <= err_d;
         slot_q     <= slot_d;
      end
   end

   assign err_len = err_q;
   assign m_data  = run_max_q;

   max_n10 #(.BW(BW)) u_tree (
      .clk      (clk),
      .den_in   (den_in),
      .data_in0 (slot_q[0]),
      .data_in1 (slot_q[1]),
      .data_in2 (slot_q[2]),
      .data_in3 (slot_q[3]),
      .data_in4 (slot_q[4]),
      .data_in5 (slot_q[5]),
      .data_in6 (slot_q[6]),
      .data_in7 (slot_q[7]),
      .data_in8 (slot_q[8]),
      .data_in9 (slot_q[9]),
      .den_out  (den_out),
      .data_max (data_max)
   );

endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: frame-level max model plus directed frames with literal results.
// Latency: checks result timing for a contiguous 10-sample frame.
// Backpressure: exercises s_valid gaps, m_ready stalls and ignored starts.
module tb_max_pool_ctrl;

   localparam int BW  = 8;
   localparam int LW  = 16;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] cfg_len = '0;
   logic          err_len, busy, s_ready, m_valid;
   logic          s_valid = 1'b0;
   logic [BW-1:0] s_data = '0;
   logic [BW-1:0] m_data;
   logic          m_ready = 1'b1;

   always #5 clk = ~clk;

   max_pool_ctrl #(.BW(BW), .LW(LW), .LAT(LAT)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .cfg_len (cfg_len),
      .err_len (err_len),
      .busy    (busy),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
   );

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_to(input string name);
      n_chk++;
      $display("FAIL %s: bound expired, got no event, expected one (cycle %0d)", name, cyc);
   endtask

   // ---------------- frame-level model and per-cycle compare ----------------
   bit  chk_en = 0;
   bit  busy_m = 0, err_m = 0;
   int  frame_len_m = 0, acc_m = 0, grp_max_m = 0;
   int  exp_q[$];
   int  iss_cnt = 0, mv_cyc = 0, first_acc = -1, first_mv = 0;
   int  err_cnt = 0, mv_all = 0, frames_done = 0, last_res = -1;
   int  done_iss = 0, done_mv = 0, done_lat = 0;
   bit  prev_hold = 0;
   logic [BW-1:0] prev_dat = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, busy_m);
         check("err_len", err_len, err_m);
         if (!busy_m) begin
            check("s_ready_idle", s_ready, 0);
            check("m_valid_idle", m_valid, 0);
         end
         if (prev_hold) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_dat);
         end
         if (m_valid) begin
            check("m_valid_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("m_data", m_data, exp_q[0]);
         end
      end
      if (err_len) err_cnt++;
      if (m_valid) mv_all++;
      prev_hold = m_valid && !m_ready;
      prev_dat  = m_data;
      if (!rst_n) begin
         busy_m = 0; err_m = 0; exp_q.delete();
         acc_m = 0; grp_max_m = 0; frame_len_m = 0;
         iss_cnt = 0; mv_cyc = 0; first_acc = -1; prev_hold = 0;
      end else begin
         err_m = !busy_m && start && (cfg_len == '0);
         if (dut.den_in) iss_cnt++;
         if (s_valid && s_ready) begin
            if (acc_m == 0) first_acc = cyc;
            if (int'(s_data) > grp_max_m) grp_max_m = int'(s_data);
            acc_m++;
            if (acc_m == frame_len_m) exp_q.push_back(grp_max_m);
         end
         if (m_valid) begin
            if (mv_cyc == 0) first_mv = cyc;
            mv_cyc++;
         end
         if (m_valid && m_ready) begin
            last_res = int'(m_data);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (chk_en) check("issues_per_frame", iss_cnt, (frame_len_m + 9) / 10);
            done_iss = iss_cnt;
            done_mv  = mv_cyc;
            done_lat = first_mv - first_acc;
            frames_done++;
            busy_m = 0;
         end else if (!busy_m && start && (cfg_len != '0)) begin
            busy_m = 1; frame_len_m = int'(cfg_len);
            acc_m = 0; grp_max_m = 0; iss_cnt = 0; mv_cyc = 0; first_acc = -1;
         end
      end
   end

   // ---------------- drivers ----------------
   logic [BW-1:0] samp[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int len);
      int t;
      t = 0;
      while (busy && t < 300) begin tick(); t++; end
      if (busy) fail_to("start_wait");
      start = 1'b1;
      cfg_len = LW'(len);
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int gap, input int start_at);
      int t;
      for (int i = 0; i < samp.size(); i++) begin
         s_valid = 1'b1;
         s_data  = samp[i];
         if (i == start_at) begin start = 1'b1; cfg_len = LW'(3); end
         t = 0;
         while (1) begin
            @(negedge clk);
            if (s_ready) break;
            t++;
            if (t > 100) begin
               fail_to("send_ready");
               s_valid = 1'b0; start = 1'b0;
               return;
            end
         end
         tick();
         s_valid = 1'b0;
         start   = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic wait_frame(input int prev);
      int t;
      t = 0;
      while (frames_done == prev && t < 300) begin tick(); t++; end
      if (frames_done == prev) fail_to("frame_done");
   endtask

   task automatic wait_mvalid();
      int t;
      t = 0;
      while (1) begin
         @(negedge clk);
         if (m_valid) break;
         t++;
         if (t > 300) begin fail_to("m_valid_rise"); return; end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int f, e0, m0;
      rst_n = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_err_len", err_len, 0);
      check("rst_m_data", m_data, 0);
      tick();
      rst_n = 1'b1;
      chk_en = 1;

      // 1: ten samples 9..0, contiguous
      f = frames_done;
      do_start(10);
      samp.delete();
      for (int i = 0; i < 10; i++) samp.push_back(BW'(9 - i));
      send(0, -1);
      wait_frame(f);
      check("t1_result", last_res, 9);
      check("t1_latency", done_lat, 16);
      check("t1_mvalid_cycles", done_mv, 1);
      check("t1_issues", done_iss, 1);

      // 2: 23 samples, three groups, last one short
      f = frames_done;
      do_start(23);
      samp.delete();
      for (int i = 0; i < 23; i++) samp.push_back((i == 22) ? BW'(200) : BW'(5));
      send(0, -1);
      wait_frame(f);
      check("t2_result", last_res, 200);
      check("t2_issues", done_iss, 3);

      // 3: single zero sample, then a zero-length start
      f = frames_done;
      do_start(1);
      samp.delete();
      samp.push_back(BW'(0));
      send(0, -1);
      wait_frame(f);
      check("t3_result", last_res, 0);
      check("t3_issues", done_iss, 1);
      tick();
      e0 = err_cnt;
      m0 = mv_all;
      do_start(0);
      repeat (6) tick();
      check("t3_err_pulses", err_cnt - e0, 1);
      check("t3_no_mvalid", mv_all - m0, 0);
      check("t3_busy", busy, 0);

      // 4: gappy input, output stalled five cycles
      f = frames_done;
      m_ready = 1'b0;
      do_start(20);
      samp.delete();
      for (int i = 0; i < 20; i++) samp.push_back((i == 13) ? BW'(77) : BW'(i * 3));
      send(1, -1);
      wait_mvalid();
      repeat (5) tick();
      m_ready = 1'b1;
      wait_frame(f);
      check("t4_result", last_res, 77);
      check("t4_mvalid_cycles", done_mv, 6);

      // 5: reset just after an issue with 250 in flight, then a fresh frame
      f = frames_done;
      do_start(20);
      samp.delete();
      for (int i = 0; i < 10; i++) samp.push_back((i == 4) ? BW'(250) : BW'(i));
      send(0, -1);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_aborted", frames_done - f, 0);
      do_start(10);
      samp.delete();
      for (int i = 0; i < 10; i++) samp.push_back((i == 6) ? BW'(17) : BW'(i));
      send(0, -1);
      wait_frame(f);
      check("t5_result", last_res, 17);
      check("t5_issues", done_iss, 1);

      // 6: stray starts in FILL and OUT, back-to-back frames
      f = frames_done;
      do_start(12);
      samp.delete();
      for (int i = 0; i < 12; i++) samp.push_back((i == 7) ? BW'(33) : BW'(i + 1));
      send(0, 4);
      m_ready = 1'b0;
      wait_mvalid();
      tick();
      start = 1'b1;
      cfg_len = LW'(7);
      tick();
      start = 1'b0;
      m_ready = 1'b1;
      wait_frame(f);
      check("t6a_result", last_res, 33);
      check("t6a_issues", done_iss, 2);
      f = frames_done;
      do_start(15);
      samp.delete();
      for (int i = 0; i < 15; i++) samp.push_back((i == 14) ? BW'(44) : BW'(i));
      send(0, -1);
      wait_frame(f);
      check("t6b_result", last_res, 44);
      check("t6b_issues", done_iss, 2);
      f = frames_done;
      do_start(5);
      samp.delete();
      samp.push_back(BW'(3));
      samp.push_back(BW'(11));
      samp.push_back(BW'(2));
      samp.push_back(BW'(7));
      samp.push_back(BW'(0));
      send(0, -1);
      wait_frame(f);
      check("t6c_result", last_res, 11);
      check("t6c_issues", done_iss, 1);

      repeat (4) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/max_pool_ctrl.md
Name: max_pool_ctrl

Overview:
Frame-level max-pooling controller that sequences the existing 10-input max pipeline max_n10, which has 4-cycle latency from den_in to den_out.
- Accepts a serial stream of unsigned BW-bit samples under valid/ready.
- Packs the samples into 10-wide groups and issues each group to the tree with den_in.
- Folds the tree results into a running maximum.
- Emits one maximum per frame of cfg_len samples.
Sits between the sample source (e.g. line buffer) and downstream pooling/threshold logic.

Parameters:
BW, 8, sample and result width (unsigned); passed to max_n10.
LW, 16, width of cfg_len and the remaining-sample counter.
LAT, 4, max_n10 latency; sizes the in-flight counter (width clog2(LAT+2)).

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  reset, synchronous, active-low.
start  in  1  frame start request; honoured only in IDLE.
cfg_len  in  LW  samples in the frame; sampled when start is accepted.
err_len  out  1  one-cycle pulse when start arrives in IDLE with cfg_len==0.
busy  out  1  high in every state except IDLE.
s_valid  in  1  input sample valid.
s_data  in  BW  input sample.
s_ready  out  1  high only in FILL.
m_valid  out  1  frame result valid; high only in OUT.
m_data  out  BW  frame maximum; held stable while m_valid && !m_ready.
m_ready  in  1  downstream accept.

Behaviour:
Reset:
- rst_n low at posedge: state=IDLE.
- Slot buffer, slot index, remaining count, in-flight count and run_max all cleared to 0.
- All outputs 0.
- Reset has priority over every other event.
- A reset mid-frame aborts that frame; no result is emitted for it.

States:
- IDLE:
  - start && cfg_len!=0 → latch rem=cfg_len, idx=0, run_max=0, slots=0; go to FILL.
  - start && cfg_len==0 → err_len=1 for one cycle; stay in IDLE.
- FILL:
  - s_ready=1. A handshake (s_valid && s_ready) writes slot[idx]=s_data, idx++, rem--.
  - If the handshake fills idx==9 or makes rem==0, go to ISSUE next cycle.
  - s_valid gaps are allowed; state and counters hold.
- ISSUE (exactly 1 cycle):
  - s_ready=0. Drive den_in=1 and data_inK=slot[K]. Unwritten slots are 0, the unsigned identity for max, so short final groups are zero-padded.
  - In-flight count +1. Clear slots, idx=0.
  - rem>0 → FILL; rem==0 → DRAIN.
  - Throughput: 10 samples per 11 cycles.
- DRAIN:
  - Wait until the in-flight count is 0, then go to OUT.
- OUT:
  - m_valid=1, m_data=run_max.
  - m_valid && m_ready → IDLE; m_valid drops the next cycle.

den_in is 0 in every state except ISSUE.

Tree return path (in all states):
- When den_out && inflight!=0: run_max <= (data_max > run_max) ? data_max : run_max, and inflight decrements.
- When den_out && inflight==0: ignore it. This discards stale tree output after reset, because max_n10 has no reset.
- Issue and return in the same cycle leave the count unchanged.

Timing:
- cfg_len=10, contiguous input: samples accepted cycles 0-9, ISSUE cycle 10, den_out cycle 14, DRAIN sees count 0 cycle 15, m_valid cycle 16.
- Accept-to-result latency after ISSUE is LAT+2 cycles.

Other rules:
- start outside IDLE is ignored.
- cfg_len changes after latch have no effect.
- Groups per frame = ceil(cfg_len/10).
- rem and cfg_len are unsigned LW-bit values; cfg_len=2^LW-1 is supported.

Decomposition:
- Shared package pool_pkg holds:
  - constant TREE_N=10;
  - state enum {IDLE, FILL, ISSUE, DRAIN, OUT};
  - default BW/LAT constants, reused by later pooling blocks.
- One sub-module: max_n10 (existing), instantiated once with BW passed through.
- The FSM, slot buffer and running-max fold stay in max_pool_ctrl.

Test Plan:
1. cfg_len=10, samples 9,8,...,0 contiguous, m_ready=1 → m_data=9; m_valid exactly at cycle 16 after the first accept, for 1 cycle; den_in pulsed once.
2. cfg_len=23, all samples 5 except sample 22=200 → three ISSUE pulses (last padded with 7 zeros); m_data=200.
3. cfg_len=1, sample 0x00; then cfg_len=0 start → first frame m_data=0; second start gives a one-cycle err_len pulse, busy stays 0, no m_valid.
4. cfg_len=20, s_valid toggled 1/0 each cycle, m_ready held 0 for 5 cycles once m_valid rises → m_valid and m_data=max stable for 5 cycles; single accept then IDLE.
5. rst_n low 1 cycle right after an ISSUE (group max 250 in flight), then a new frame cfg_len=10 with max 17 → stale den_out ignored; m_data=17.
6. start pulsed during FILL and OUT, with back-to-back frames (max 33 then 44) → extra starts ignored; results 33 then 44; run_max cleared between frames.
